uart_tx_wb: RTL

UART_TX_WB -- requirements
Module: uart_tx_wb

---
 rtl/uart_tx_wb_pkg.sv | 23 ++
 rtl/uart_tx_wb_sync_fifo.sv | 62 ++++++
 rtl/uart_tx_wb.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_wb_pkg.sv
// Shared types for the Wishbone UART transmitter.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit to each frame).
package uart_tx_wb_pkg;

  // Transmit FSM states; PARITY only exists when parity is compiled in.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_tx_state_t;

  // Wishbone register map (single address bit).
  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  // Width of the status byte returned on a status read.
  localparam int unsigned STATUS_W = 8;

endpackage

// File: rtl/uart_tx_wb_sync_fifo.sv
// Synchronous first-word-fall-through FIFO used as the UART transmit queue.
// Push is ignored when full, pop is ignored when empty; fullness is judged
// on the current count, so a push into a full FIFO is dropped even if a pop
// happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage array: written on accepted pushes only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_wb.sv
// Wishbone classic slave UART transmitter with a TX FIFO.
//   adr 0 write : queue a byte (dropped and ovf set when the FIFO is full)
//   adr 1 read  : status {4'b0, ovf, busy, empty, full}; clears ovf
// Optional feature macro: UART_TX_PARITY_EN (even parity bit between data and stop).
module uart_tx_wb
  import uart_tx_wb_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic       adr_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  output logic       uart_tx
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_wb: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_wb: FIFO_DEPTH must be a power of two in 2..256");
  end

  // Bus side
  logic                req;
  logic                data_wr;
  logic                status_rd;
  logic                ovf;
  logic [STATUS_W-1:0] status;

  // FIFO side
  logic       fifo_push;
  logic       fifo_pop;
  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;

  // Transmitter state
  uart_tx_state_t   state, state_next;
  logic [CNT_W-1:0] baud_cnt, baud_next;
  logic [2:0]       bit_cnt, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic             tx_next;
  logic             busy;
  logic             bit_done;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_next;
`endif

  assign req       = cyc_i & stb_i & ~ack_o;
  assign data_wr   = req & we_i & (adr_i == ADDR_DATA);
  assign status_rd = req & ~we_i & (adr_i == ADDR_STATUS);
  assign fifo_push = data_wr & ~fifo_full;
  assign busy      = (state != IDLE);
  assign status    = {4'b0000, ovf, busy, fifo_empty, fifo_full};
  assign bit_done  = (baud_cnt == CNT_LAST);

  // Single-cycle ack, registered read data and the sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_o <= 1'b0;
      dat_o <= '0;
      ovf   <= 1'b0;
    end else begin
      ack_o <= req;
      dat_o <= status_rd ? status : '0;
      if (status_rd) begin
        ovf <= 1'b0;
      end else if (data_wr && fifo_full) begin
        ovf <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (fifo_push),
    .push_data (dat_i),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Transmitter registers; uart_tx is a flop so the line never glitches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      uart_tx   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_cnt   <= bit_next;
      shift_reg <= shift_next;
      uart_tx   <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_next;
`endif
    end
  end

  // Next-state logic; tx_next is the line level for the following cycle,
  // so each transition also selects the first level of the new state.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt + CNT_W'(1);
    bit_next   = bit_cnt;
    shift_next = shift_reg;
    tx_next    = uart_tx;
    fifo_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_q;
`endif
    case (state)
      IDLE: begin
        baud_next = '0;
        tx_next   = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_dout;
          state_next = START;
          tx_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_next = ^fifo_dout;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
          tx_next    = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_next = '0;
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            tx_next    = parity_q;
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            bit_next   = bit_cnt + 3'd1;
            shift_next = {1'b0, shift_reg[7:1]};
            tx_next    = shift_reg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          baud_next  = '0;
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          baud_next = '0;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_dout;
            state_next = START;
            tx_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_next = ^fifo_dout;
`endif
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = '0;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule
